prog_counter: RTL
=================

# prog_counter

Programmable up/down counter for encoder tick accumulation, PWM period generation and timeouts in the FPGA motor-control fabric. It succeeds the fixed-limit counter. It adds runtime limits, direction and step size, three boundary modes (wrap, saturate, one-shot), synchronous load, compare match and configuration-error detection. All outputs are registered.

## Interface
- NBITS, 16, counter width in bits
- RST_VAL, 0, value of count after rst
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear of count to min_val
- load  in  1  synchronous load of load_val
- load_val  in  NBITS  value loaded when load=1
- en  in  1  perform one step this cycle
- dir  in  1  1 = count up, 0 = count down
- step  in  NBITS  unsigned step magnitude
- min_val  in  NBITS  lower limit, inclusive
- max_val  in  NBITS  upper limit, inclusive
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- cmp_val  in  NBITS  compare value
- count  out  NBITS  current count
- overflow  out  1  one-cycle pulse: upward step crossed max_val
- underflow  out  1  one-cycle pulse: downward step crossed min_val
- cmp_match  out  1  one-cycle pulse: an update made count equal cmp_val
- done  out  1  one-shot terminated; level
- cfg_err  out  1  min_val > max_val; level, registered

## Operation
- Priority per cycle: rst > clr > load > en. Lower-priority requests in the same cycle are discarded.
- rst: count=RST_VAL; overflow, underflow, cmp_match, done and cfg_err are 0; state=RUN.
- clr: count=min_val; state=RUN; done=0.
- load:
  - count=load_val, clamped to min_val if below, or to max_val if above.
  - state=RUN; done=0.
- cfg_err register = (min_val > max_val), updated every non-reset cycle. While cfg_err is set, en steps are ignored and count holds. clr and load still act, with no clamping on load.
- Arithmetic is done in NBITS+1 unsigned bits, so no silent modular wrap.
  - Up: sum = count + step; boundary when sum > max_val.
  - Down: boundary when count < min_val + step (NBITS+1 bits).
- Non-boundary step: count = count ± step.
- Boundary behaviour by mode:
  - Wrap up: count=min_val, overflow=1.
  - Wrap down: count=max_val, underflow=1.
  - Saturate: count = max_val (up) or min_val (down). The matching flag pulses on every en cycle that hits the boundary, including repeated cycles while already at the limit.
  - One-shot: count = limit (max_val up, min_val down). The matching flag pulses, done=1, state→DONE.
- State machine: RUN, DONE.
  - RUN→DONE only on a one-shot boundary.
  - DONE→RUN only on clr, load or rst.
  - In DONE, en is ignored and there are no pulses. Changing mode does not leave DONE.
- step=0 with en: count holds; no overflow/underflow. cmp_match is not re-fired.
- Limits changed at runtime, leaving count outside [min_val,max_val]: the next en step is evaluated with the rules above. Example: count > max_val going up is a boundary.
- cmp_match=1 in the cycle after any clr, load or en update whose new count == cmp_val and differs from the old count. Otherwise 0.

## Timing
- count updates on the same edge that samples en, clr or load. Latency is 1 clock.
- overflow, underflow and cmp_match are asserted on the same edge as the corresponding count update, for exactly 1 cycle, then cleared.
- done rises on the same edge count reaches the limit.
- cfg_err follows min_val/max_val with 1 clock latency.
- No combinational input→output paths.

## Test plan
- Wrap up, NBITS=8, min=10, max=20, step=3, dir=1, mode=00, count=10, en held → count 13, 16, 19, 10. overflow=1 only on the cycle count returns to 10.
- Wrap down, min=10, max=20, step=4, dir=0, count=12, en 1 cycle → count=20, underflow pulse. Repeat the scenario with step=0 → count stays 12, no pulse.
- Saturate, min=0, max=255, step=1, dir=1, count=254, en for 3 cycles → count 255, 255, 255. overflow=0 on the first cycle, then 1 on each of the next two.
- One-shot, min=0, max=5, step=2, count=0, en held → 2, 4, 5 with overflow pulse and done=1, then holds at 5. clr → count=0, done=0. Same test with rst asserted while count=4 → count=RST_VAL, done=0.
- Priority/clamp, min=0, max=40:
  - clr+load+en in one cycle → count=0.
  - load=1 with load_val=50 → count=40.
  - cmp_val=40 → cmp_match pulse on the load cycle.
- Config error, min=30, max=20, count=25, en for 2 cycles → count stays 25; cfg_err=1 one clock after the limits are applied. Restore max=40 → cfg_err=0 next cycle, en steps resume.

Source files
------------

// File: rtl/prog_counter.sv
// Programmable up/down counter: runtime limits, direction and step, with wrap,
// saturate and one-shot boundary modes, synchronous clear/load, compare match
// and a limit-ordering error flag. Every output comes straight from a flop.
module prog_counter #(
  parameter int               NBITS   = 16,
  parameter logic [NBITS-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [NBITS-1:0] step,
  input  logic [NBITS-1:0] min_val,
  input  logic [NBITS-1:0] max_val,
  input  logic [1:0]       mode,
  input  logic [NBITS-1:0] cmp_val,
  output logic [NBITS-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             cmp_match,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic {RUN, DONE} state_t;

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;

  state_t           state_q;
  logic [NBITS-1:0] count_q;
  logic             ovf_q, unf_q, cmp_q, cfg_err_q;

  // Step evaluation, one bit wider than the count so nothing wraps silently
  logic [NBITS:0]   sum_up, lim_dn;
  logic             bnd;
  logic [NBITS-1:0] step_cnt;
  logic             step_ovf, step_unf, step_fin;

  // Load value, clamped into the limits unless the limits are inconsistent
  logic [NBITS-1:0] load_cnt;

  // Selected update for this cycle
  logic             upd;
  logic [NBITS-1:0] cnt_d;
  logic             ovf_d, unf_d, fin_d;

  // Next count for an enabled step, including boundary handling per mode
  always_comb begin
    sum_up   = {1'b0, count_q} + {1'b0, step};
    lim_dn   = {1'b0, min_val} + {1'b0, step};
    bnd      = dir ? (sum_up > {1'b0, max_val}) : ({1'b0, count_q} < lim_dn);
    step_cnt = dir ? sum_up[NBITS-1:0] : (count_q - step);
    step_ovf = 1'b0;
    step_unf = 1'b0;
    step_fin = 1'b0;
    if (step == '0) begin
      // Zero step never reaches a boundary, even when count is out of range
      step_cnt = count_q;
    end else if (bnd) begin
      step_ovf = dir;
      step_unf = !dir;
      case (mode)
        MODE_SAT:  step_cnt = dir ? max_val : min_val;
        MODE_ONCE: begin
          step_cnt = dir ? max_val : min_val;
          step_fin = 1'b1;
        end
        default:   step_cnt = dir ? min_val : max_val;
      endcase
    end
  end

  // Load clamping, skipped while the limits are known to be inverted
  always_comb begin
    load_cnt = load_val;
    if (!cfg_err_q) begin
      if (load_val < min_val)      load_cnt = min_val;
      else if (load_val > max_val) load_cnt = max_val;
    end
  end

  // Priority select: clr > load > en; en only acts while running with sane limits
  always_comb begin
    upd   = 1'b0;
    cnt_d = count_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    fin_d = 1'b0;
    if (clr) begin
      upd   = 1'b1;
      cnt_d = min_val;
    end else if (load) begin
      upd   = 1'b1;
      cnt_d = load_cnt;
    end else if (en && (state_q == RUN) && !cfg_err_q) begin
      upd   = 1'b1;
      cnt_d = step_cnt;
      ovf_d = step_ovf;
      unf_d = step_unf;
      fin_d = step_fin;
    end
  end

  // Registered count, pulses, RUN/DONE state and limit-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      count_q   <= RST_VAL;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cmp_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (min_val > max_val);
      count_q   <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cmp_q     <= upd && (cnt_d == cmp_val) && (cnt_d != count_q);
      if (clr || load)  state_q <= RUN;
      else if (fin_d)   state_q <= DONE;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign cmp_match = cmp_q;
  assign done      = (state_q == DONE);
  assign cfg_err   = cfg_err_q;

endmodule
